// File: rtl/config_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader: FSM encoding and CRC-16-CCITT constants.
package config_chain_loader_pkg;

  localparam int unsigned CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One bit-serial CRC-16-CCITT step, MSB-first, no reflection.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                 input logic bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Word-stream handshake between the bitstream source and the chain loader.
interface config_chain_loader_if #(
  parameter int unsigned WORD_W = 8
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/config_chain_loader_crc16_serial.sv
// Bit-serial CRC-16 accumulator; clr reloads the init value and wins over en.
module crc16_serial
  import config_chain_loader_pkg::*;
(
  input  logic             config_clk,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  // Absorb one bit per enabled cycle.
  always_ff @(posedge config_clk) begin
    if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Shifts a word-stream configuration image into the serial config chain, then optionally
// recirculates the chain once and compares the readback CRC with the load CRC.
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned VERIFY_EN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  config_clk,
  input  logic                  GSR,
  input  logic                  start,
  config_chain_loader_if.slave  stream,
  output logic                  config_in,
  output logic                  config_en,
  input  logic                  config_out,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_ok,
  output logic [CRC_W-1:0]      crc_val
);

  localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int unsigned BCNT_W    = $clog2(WORD_W + 1);

  state_t             state;
  logic [WORD_W-1:0]  word_buf;
  logic [BCNT_W-1:0]  buf_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   words_taken;
  logic               ok_valid;

  logic               in_load;
  logic               in_verify;
  logic               shifting;
  logic               rdy;
  logic               take;
  logic               start_acc;
  logic               last_bit;
  logic               crc_clr;
  logic [BCNT_W-1:0]  fill_cnt;
  logic [CRC_W-1:0]   crc_load;
  logic [CRC_W-1:0]   crc_rb;

  // Decode of registered state: shift qualifiers, refill handshake, chain drive.
  assign in_load     = (state == LOAD);
  assign in_verify   = (state == VERIFY);
  assign shifting    = in_load && (buf_cnt != BCNT_W'(0));
  assign rdy         = in_load && (buf_cnt <= BCNT_W'(1)) && (words_taken < CNT_W'(NUM_WORDS));
  assign take        = rdy && stream.s_valid;
  assign start_acc   = (state == IDLE) && start;
  assign last_bit    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign crc_clr     = GSR || start_acc;
  assign fill_cnt    = (words_taken == CNT_W'(NUM_WORDS - 1)) ? BCNT_W'(LAST_BITS) : BCNT_W'(WORD_W);

  assign stream.s_ready = rdy;
  assign config_en      = shifting || in_verify;
  assign config_in      = in_verify ? config_out : (shifting & word_buf[0]);
  assign crc_val        = crc_load;
  assign crc_ok         = ok_valid && ((VERIFY_EN == 0) || (crc_rb == crc_load));

  // Loader FSM with word buffer, bit counter and status flags.
  always_ff @(posedge config_clk) begin
    if (GSR) begin
      state       <= IDLE;
      word_buf    <= '0;
      buf_cnt     <= '0;
      bit_cnt     <= '0;
      words_taken <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok_valid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            word_buf    <= '0;
            buf_cnt     <= '0;
            bit_cnt     <= '0;
            words_taken <= '0;
            busy        <= 1'b1;
            ok_valid    <= 1'b0;
          end
        end
        LOAD: begin
          if (take) begin
            word_buf    <= stream.s_data;
            buf_cnt     <= fill_cnt;
            words_taken <= words_taken + CNT_W'(1);
          end else if (shifting) begin
            word_buf <= word_buf >> 1;
            buf_cnt  <= buf_cnt - BCNT_W'(1);
          end
          if (shifting) begin
            if (last_bit) begin
              bit_cnt <= '0;
              if (VERIFY_EN != 0) begin
                state <= VERIFY;
              end else begin
                state    <= DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                ok_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        VERIFY: begin
          if (last_bit) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            ok_valid <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  crc16_serial u_crc_load (
    .config_clk (config_clk),
    .clr        (crc_clr),
    .en         (shifting),
    .bit_in     (word_buf[0]),
    .crc        (crc_load)
  );

  crc16_serial u_crc_rb (
    .config_clk (config_clk),
    .clr        (crc_clr),
    .en         (in_verify),
    .bit_in     (config_out),
    .crc        (crc_rb)
  );

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench: a 20-bit verifying loader and an 8-bit non-verifying loader, each driving
// a shift-register model of the configuration chain.
module tb_config_chain_loader;

  logic        clk;
  logic        gsr_a, gsr_b;
  logic        start_a, start_b;
  logic        cin_a, en_a, busy_a, done_a, ok_a;
  logic        cin_b, en_b, busy_b, done_b, ok_b;
  logic [15:0] crcv_a, crcv_b;
  logic [19:0] chain_a, nxt_a;
  logic [7:0]  chain_b;
  logic        src_clr, cnt_clr, src_stall, corrupt_arm;
  logic [2:0]  src_idx;
  int          stall_left;
  int          en_cnt_a;
  int          n_checks, n_errors;
  logic [15:0] crc_exp_a, crc_exp_b;

  config_chain_loader_if #(.WORD_W(8)) bus_a ();
  config_chain_loader_if #(.WORD_W(8)) bus_b ();

  config_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .VERIFY_EN(1), .CNT_W(16)) dut_a (
    .config_clk (clk),
    .GSR        (gsr_a),
    .start      (start_a),
    .stream     (bus_a),
    .config_in  (cin_a),
    .config_en  (en_a),
    .config_out (chain_a[0]),
    .busy       (busy_a),
    .done       (done_a),
    .crc_ok     (ok_a),
    .crc_val    (crcv_a)
  );

  config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .VERIFY_EN(0), .CNT_W(16)) dut_b (
    .config_clk (clk),
    .GSR        (gsr_b),
    .start      (start_b),
    .stream     (bus_b),
    .config_in  (cin_b),
    .config_en  (en_b),
    .config_out (chain_b[0]),
    .busy       (busy_b),
    .done       (done_b),
    .crc_ok     (ok_b),
    .crc_val    (crcv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word source for loader A: A5, 3C, 0F, optionally withholding valid for 3 ready cycles per gap.
  always @(posedge clk) begin
    if (src_clr) begin
      src_idx    <= 3'd0;
      stall_left <= 0;
    end else if (bus_a.s_ready && bus_a.s_valid) begin
      src_idx    <= src_idx + 3'd1;
      stall_left <= src_stall ? 3 : 0;
    end else if (bus_a.s_ready && stall_left != 0) begin
      stall_left <= stall_left - 1;
    end
  end

  always_comb begin
    case (src_idx)
      3'd0:    bus_a.s_data = 8'hA5;
      3'd1:    bus_a.s_data = 8'h3C;
      3'd2:    bus_a.s_data = 8'h0F;
      default: bus_a.s_data = 8'h00;
    endcase
  end
  assign bus_a.s_valid = (src_idx < 3'd3) && (stall_left == 0);

  assign bus_b.s_data  = 8'hFF;
  assign bus_b.s_valid = 1'b1;

  // Chain model A: head receives config_in, tail is bit 0; optional flip of bit 7 on the last load shift.
  always @(posedge clk) begin
    if (cnt_clr) en_cnt_a <= 0;
    else if (en_a) en_cnt_a <= en_cnt_a + 1;
    if (en_a) begin
      nxt_a = {cin_a, chain_a[19:1]};
      if (corrupt_arm && !cnt_clr && en_cnt_a == 19) nxt_a[7] = ~nxt_a[7];
      chain_a <= nxt_a;
    end
  end

  // Chain model B.
  always @(posedge clk) begin
    if (en_b) chain_b <= {cin_b, chain_b[7:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Run one load on A; cycle 1 is the first cycle after the start edge.
  task automatic run_a(input logic stall, input logic corrupt, input logic poke,
                       output int done_at, output int en_hi, output int en_lo_busy);
    src_stall   = stall;
    corrupt_arm = corrupt;
    src_clr = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    src_clr = 1'b0; cnt_clr = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    done_at = -1; en_hi = 0; en_lo_busy = 0;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      if (done_a) done_at = n;
      if (busy_a && en_a) en_hi++;
      if (busy_a && !en_a) en_lo_busy++;
      if (poke) start_a = (n == 5) || done_a;
      @(negedge clk);
    end
    start_a = 1'b0;
    if (done_at < 0) check("a_done_timeout", 32'd0, 32'd1);
  endtask

  int d, h, l, dn, bz;

  initial begin
    n_checks = 0; n_errors = 0;
    gsr_a = 1'b1; gsr_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    src_clr = 1'b1; cnt_clr = 1'b1; src_stall = 1'b0; corrupt_arm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready",   32'(bus_a.s_ready), 32'd0);
    check("rst_config_en", 32'(en_a),   32'd0);
    check("rst_config_in", 32'(cin_a),  32'd0);
    check("rst_busy",      32'(busy_a), 32'd0);
    check("rst_done",      32'(done_a), 32'd0);
    check("rst_crc_ok",    32'(ok_a),   32'd0);
    check("rst_crc_val",   32'(crcv_a), 32'h0000FFFF);
    check("rst_crc_val_b", 32'(crcv_b), 32'h0000FFFF);
    gsr_a = 1'b0; gsr_b = 1'b0; src_clr = 1'b0; cnt_clr = 1'b0;

    crc_exp_a = crc_ref(64'h00000000000F3CA5, 20);
    crc_exp_b = crc_ref(64'h00000000000000FF, 8);

    // Clean load and verify, no stalls.
    run_a(1'b0, 1'b0, 1'b0, d, h, l);
    check("clean_done_cycle", 32'(d), 32'd42);
    check("clean_en_high",    32'(h), 32'd40);
    check("clean_en_low",     32'(l), 32'd1);
    check("clean_chain",      32'(chain_a), 32'h000F3CA5);
    check("clean_crc_ok",     32'(ok_a), 32'd1);
    check("clean_crc_val",    32'(crcv_a), 32'(crc_exp_a));
    repeat (3) @(negedge clk);
    check("clean_crc_ok_held",  32'(ok_a), 32'd1);
    check("clean_crc_val_held", 32'(crcv_a), 32'(crc_exp_a));

    // Same image with three-cycle source stalls between words.
    run_a(1'b1, 1'b0, 1'b0, d, h, l);
    check("stall_done_cycle", 32'(d), 32'd48);
    check("stall_en_high",    32'(h), 32'd40);
    check("stall_en_low",     32'(l), 32'd7);
    check("stall_chain",      32'(chain_a), 32'h000F3CA5);
    check("stall_crc_ok",     32'(ok_a), 32'd1);
    check("stall_crc_val",    32'(crcv_a), 32'(crc_exp_a));

    // Chain bit 7 flipped between load and readback.
    run_a(1'b0, 1'b1, 1'b0, d, h, l);
    check("corrupt_done_cycle", 32'(d), 32'd42);
    check("corrupt_crc_ok",     32'(ok_a), 32'd0);
    check("corrupt_crc_val",    32'(crcv_a), 32'(crc_exp_a));
    check("corrupt_chain",      32'(chain_a), 32'h000F3C25);
    corrupt_arm = 1'b0;

    // Start pulses during LOAD and DONE must be ignored.
    run_a(1'b0, 1'b0, 1'b1, d, h, l);
    check("poke_done_cycle", 32'(d), 32'd42);
    check("poke_crc_ok",     32'(ok_a), 32'd1);
    check("poke_chain",      32'(chain_a), 32'h000F3CA5);
    dn = 0; bz = 0;
    for (int n = 0; n < 50; n++) begin
      if (done_a) dn++;
      if (busy_a) bz++;
      @(negedge clk);
    end
    check("poke_extra_done", 32'(dn), 32'd0);
    check("poke_extra_busy", 32'(bz), 32'd0);

    // GSR at the tenth shifted bit aborts the load without a done pulse.
    src_stall = 1'b0;
    src_clr = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    src_clr = 1'b0; cnt_clr = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    h = 0;
    for (int n = 0; n < 40 && h < 10; n++) begin
      if (en_a) h++;
      if (h < 10) @(negedge clk);
    end
    check("gsr_reach_bit10", 32'(h), 32'd10);
    gsr_a = 1'b1;
    @(negedge clk);
    check("gsr_config_en", 32'(en_a), 32'd0);
    check("gsr_busy",      32'(busy_a), 32'd0);
    check("gsr_s_ready",   32'(bus_a.s_ready), 32'd0);
    check("gsr_done",      32'(done_a), 32'd0);
    gsr_a = 1'b0;
    dn = 0;
    for (int n = 0; n < 60; n++) begin
      if (done_a) dn++;
      @(negedge clk);
    end
    check("gsr_no_done", 32'(dn), 32'd0);

    run_a(1'b0, 1'b0, 1'b0, d, h, l);
    check("reload_done_cycle", 32'(d), 32'd42);
    check("reload_en_high",    32'(h), 32'd40);
    check("reload_chain",      32'(chain_a), 32'h000F3CA5);
    check("reload_crc_ok",     32'(ok_a), 32'd1);
    check("reload_crc_val",    32'(crcv_a), 32'(crc_exp_a));

    // Loader B: 8-bit chain, no readback.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    d = -1; h = 0;
    for (int n = 1; n <= 100 && d < 0; n++) begin
      if (done_b) d = n;
      if (busy_b && en_b) h++;
      @(negedge clk);
    end
    check("b_done_cycle", 32'(d), 32'd10);
    check("b_en_high",    32'(h), 32'd8);
    check("b_chain",      32'(chain_b), 32'h000000FF);
    check("b_crc_ok",     32'(ok_b), 32'd1);
    check("b_crc_val",    32'(crcv_b), 32'(crc_exp_b));
    check("b_en_after",   32'(en_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
